alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/alu_op_class.sv | 23 ++
 rtl/alu_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue sequencer.
//   - ALU op-code constants (ADD=0 .. AUIPC=44) and the idle op code NOP_OP
//   - state_e    : sequencer FSM states
//   - op_class_e : issue class of an op code (single-cycle, multi-cycle,
//                  memory, invalid)
package alu_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_SLL    = 6'd2;
  localparam logic [5:0] OP_SLT    = 6'd3;
  localparam logic [5:0] OP_SLTU   = 6'd4;
  localparam logic [5:0] OP_XOR    = 6'd5;
  localparam logic [5:0] OP_SRL    = 6'd6;
  localparam logic [5:0] OP_SRA    = 6'd7;
  localparam logic [5:0] OP_OR     = 6'd8;
  localparam logic [5:0] OP_AND    = 6'd9;
  localparam logic [5:0] OP_MUL    = 6'd10;
  localparam logic [5:0] OP_MULH   = 6'd11;
  localparam logic [5:0] OP_MULHSU = 6'd12;
  localparam logic [5:0] OP_MULHU  = 6'd13;
  localparam logic [5:0] OP_DIV    = 6'd14;
  localparam logic [5:0] OP_DIVU   = 6'd15;
  localparam logic [5:0] OP_REM    = 6'd16;
  localparam logic [5:0] OP_REMU   = 6'd17;
  localparam logic [5:0] OP_ADDI   = 6'd18;
  localparam logic [5:0] OP_SLTI   = 6'd19;
  localparam logic [5:0] OP_SLTIU  = 6'd20;
  localparam logic [5:0] OP_XORI   = 6'd21;
  localparam logic [5:0] OP_ORI    = 6'd22;
  localparam logic [5:0] OP_ANDI   = 6'd23;
  localparam logic [5:0] OP_SLLI   = 6'd24;
  localparam logic [5:0] OP_SRLI   = 6'd25;
  localparam logic [5:0] OP_SRAI   = 6'd26;
  localparam logic [5:0] OP_LB     = 6'd27;
  localparam logic [5:0] OP_LH     = 6'd28;
  localparam logic [5:0] OP_LW     = 6'd29;
  localparam logic [5:0] OP_LBU    = 6'd30;
  localparam logic [5:0] OP_LHU    = 6'd31;
  localparam logic [5:0] OP_SB     = 6'd32;
  localparam logic [5:0] OP_SH     = 6'd33;
  localparam logic [5:0] OP_SW     = 6'd34;
  localparam logic [5:0] OP_BEQ    = 6'd35;
  localparam logic [5:0] OP_BNE    = 6'd36;
  localparam logic [5:0] OP_BLT    = 6'd37;
  localparam logic [5:0] OP_BGE    = 6'd38;
  localparam logic [5:0] OP_BLTU   = 6'd39;
  localparam logic [5:0] OP_BGEU   = 6'd40;
  localparam logic [5:0] OP_JAL    = 6'd41;
  localparam logic [5:0] OP_JALR   = 6'd42;
  localparam logic [5:0] OP_LUI    = 6'd43;
  localparam logic [5:0] OP_AUIPC  = 6'd44;

  // Op code the ALU decodes as "no action".
  localparam logic [5:0] NOP_OP    = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SINGLE  = 2'd0,
    MULTI   = 2'd1,
    MEM     = 2'd2,
    INVALID = 2'd3
  } op_class_e;

endpackage

// File: rtl/alu_op_class.sv
// alu_op_class: combinational op-code classifier.
//   i_op    : 6-bit ALU op code
//   o_class : INVALID (>44), MULTI (divide/remainder 14..17),
//             MEM (load/store 27..34), SINGLE otherwise
module alu_op_class
  import alu_pkg::*;
(
  input  logic [5:0] i_op,
  output op_class_e  o_class
);

  always_comb begin
    o_class = SINGLE;
    if (i_op > OP_AUIPC) begin
      o_class = INVALID;
    end else if (i_op >= OP_DIV && i_op <= OP_REMU) begin
      o_class = MULTI;
    end else if (i_op >= OP_LB && i_op <= OP_SW) begin
      o_class = MEM;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one op at a time to an external ALU and collects
// its result.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_req_valid / o_req_ready    : request handshake from the control unit
//   i_op, i_IR, i_A, i_B, i_PC   : op code and operands, latched on accept
//   i_flush                      : abort the in-flight op
//   o_alu_*                      : op and operands driven to the ALU
//   i_alu_*                      : ALU result, write-back and jump outputs
//   o_done                       : one-cycle completion pulse
//   o_result, o_jump_address, o_wb_en, o_jump_DV, o_error
//                                : completion data, valid while o_done=1
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter logic [5:0]  NOP_OP      = alu_pkg::NOP_OP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_op,
  input  logic [31:0] i_IR,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic [31:0] i_PC,
  input  logic        i_flush,
  output logic [31:0] o_alu_instruction,
  output logic [31:0] o_alu_IR,
  output logic [31:0] o_alu_A,
  output logic [31:0] o_alu_B,
  output logic [31:0] o_alu_PC,
  output logic        o_alu_state,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_alu_jump_address,
  input  logic        i_alu_load_regfile,
  input  logic        i_alu_jump_DV,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic [31:0] o_jump_address,
  output logic        o_wb_en,
  output logic        o_jump_DV,
  output logic        o_error
);

  localparam int unsigned   CW  = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(DIV_TIMEOUT);

  state_e      state_q, state_d;
  op_class_e   cls_q, cls_d, in_cls;
  logic [5:0]  op_q, op_d;
  logic [31:0] ir_q, ir_d, a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic [31:0] result_q, result_d, jaddr_q, jaddr_d;
  logic        wb_q, wb_d, jdv_q, jdv_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        accept;

  alu_op_class u_op_class (
    .i_op    (i_op),
    .o_class (in_cls)
  );

  assign o_req_ready = (state_q == IDLE) && !i_flush && !i_rst;
  assign accept      = o_req_ready && i_req_valid;
  assign cnt_inc     = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    op_d     = op_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    pc_d     = pc_q;
    result_d = result_q;
    jaddr_d  = jaddr_q;
    wb_d     = wb_q;
    jdv_d    = jdv_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = i_op;
          cls_d    = in_cls;
          ir_d     = i_IR;
          a_d      = i_A;
          b_d      = i_B;
          pc_d     = i_PC;
          result_d = '0;
          jaddr_d  = '0;
          wb_d     = 1'b0;
          jdv_d    = 1'b0;
          err_d    = (in_cls == INVALID);
          cnt_d    = '0;
          state_d  = (in_cls == INVALID) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cls_q == MULTI) begin
          if (i_alu_load_regfile) begin
            result_d = i_alu_result;
            wb_d     = 1'b1;
            cnt_d    = '0;
            state_d  = DONE;
          end else if (cnt_inc == TMO) begin
            result_d = '0;
            wb_d     = 1'b0;
            err_d    = 1'b1;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Single-cycle and memory ops: ALU output is registered, so it is
          // valid at the end of the one WAIT cycle. Memory ops never write back.
          result_d = i_alu_result;
          jaddr_d  = i_alu_jump_address;
          jdv_d    = i_alu_jump_DV;
          wb_d     = (cls_q == SINGLE) && i_alu_load_regfile;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cls_q    <= SINGLE;
      op_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pc_q     <= '0;
      result_q <= '0;
      jaddr_q  <= '0;
      wb_q     <= 1'b0;
      jdv_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      op_q     <= op_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      jaddr_q  <= jaddr_d;
      wb_q     <= wb_d;
      jdv_q    <= jdv_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset and flush take effect on the ALU interface immediately, so the
  // ALU divide counter clears in the same cycle the abort is requested.
  always_comb begin
    o_alu_instruction = {26'd0, NOP_OP};
    o_alu_state       = 1'b0;
    if (!i_rst && !i_flush) begin
      case (state_q)
        ISSUE: begin
          o_alu_instruction = {26'd0, op_q};
          o_alu_state       = 1'b1;
        end
        WAIT: begin
          o_alu_state = 1'b1;
          if (cls_q == MULTI) o_alu_instruction = {26'd0, op_q};
        end
        default: ;
      endcase
    end
  end

  assign o_alu_IR       = i_rst ? '0 : ir_q;
  assign o_alu_A        = i_rst ? '0 : a_q;
  assign o_alu_B        = i_rst ? '0 : b_q;
  assign o_alu_PC       = i_rst ? '0 : pc_q;
  assign o_done         = (state_q == DONE) && !i_flush && !i_rst;
  assign o_result       = i_rst ? '0 : result_q;
  assign o_jump_address = i_rst ? '0 : jaddr_q;
  assign o_wb_en        = wb_q  && !i_rst;
  assign o_jump_DV      = jdv_q && !i_rst;
  assign o_error        = err_q && !i_rst;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a
// small registered ALU stand-in (single-cycle ops answer one cycle after
// issue, divides answer after a few cycles or never when hang=1).
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_req_valid, i_flush;
  logic [5:0]  i_op;
  logic [31:0] i_IR, i_A, i_B, i_PC;
  logic        o_req_ready, o_alu_state, o_done, o_wb_en, o_jump_DV, o_error;
  logic [31:0] o_alu_instruction, o_alu_IR, o_alu_A, o_alu_B, o_alu_PC;
  logic [31:0] o_result, o_jump_address;

  logic [31:0] alu_res_q, alu_jaddr_q;
  logic        alu_load_q, alu_jdv_q, noise_jdv, hang;
  int unsigned div_cnt;

  int ntests = 0;
  int nfail  = 0;

  int          lat;
  logic [31:0] obs_result, obs_jaddr, prev_instr, done_instr;
  logic        obs_wb, obs_jdv, obs_err, saw_non_nop;

  always #5 clk = ~clk;

  alu_sequencer #(.DIV_TIMEOUT(64), .NOP_OP(6'd63)) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_op               (i_op),
    .i_IR               (i_IR),
    .i_A                (i_A),
    .i_B                (i_B),
    .i_PC               (i_PC),
    .i_flush            (i_flush),
    .o_alu_instruction  (o_alu_instruction),
    .o_alu_IR           (o_alu_IR),
    .o_alu_A            (o_alu_A),
    .o_alu_B            (o_alu_B),
    .o_alu_PC           (o_alu_PC),
    .o_alu_state        (o_alu_state),
    .i_alu_result       (alu_res_q),
    .i_alu_jump_address (alu_jaddr_q),
    .i_alu_load_regfile (alu_load_q),
    .i_alu_jump_DV      (alu_jdv_q | noise_jdv),
    .o_done             (o_done),
    .o_result           (o_result),
    .o_jump_address     (o_jump_address),
    .o_wb_en            (o_wb_en),
    .o_jump_DV          (o_jump_DV),
    .o_error            (o_error)
  );

  // ALU stand-in
  always @(posedge clk) begin
    alu_res_q   <= '0;
    alu_jaddr_q <= '0;
    alu_load_q  <= 1'b0;
    alu_jdv_q   <= 1'b0;
    if (!o_alu_state) begin
      div_cnt <= 0;
    end else begin
      case (o_alu_instruction[5:0])
        OP_ADD: begin
          alu_res_q  <= o_alu_A + o_alu_B;
          alu_load_q <= 1'b1;
        end
        OP_LW: begin
          alu_res_q  <= 32'hDEADBEEF;
          alu_load_q <= 1'b1;
        end
        OP_BEQ: begin
          alu_jdv_q   <= (o_alu_A == o_alu_B);
          alu_jaddr_q <= o_alu_PC + o_alu_IR;
        end
        OP_DIV, OP_DIVU: begin
          div_cnt <= div_cnt + 1;
          if (div_cnt == 3 && !hang) begin
            alu_load_q <= 1'b1;
            alu_res_q  <= (o_alu_instruction[5:0] == OP_DIV) ?
                          32'($signed(o_alu_A) / $signed(o_alu_B)) :
                          o_alu_A / o_alu_B;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the accept edge.
  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] ir);
    for (int k = 0; k < 4 && !o_req_ready; k++) begin
      @(posedge clk); #1;
    end
    check("ready_before_issue", {31'd0, o_req_ready}, 32'd1);
    i_op = op; i_A = a; i_B = b; i_PC = pc; i_IR = ir;
    i_req_valid = 1'b1;
    if (o_alu_instruction != 32'd63) saw_non_nop = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] ir, input logic noise);
    int  cyc;
    bit  got;
    saw_non_nop = 1'b0;
    start_op(op, a, b, pc, ir);
    noise_jdv  = noise;
    cyc        = 1;
    got        = 1'b0;
    prev_instr = 32'd63;
    while (cyc < 200) begin
      if (o_alu_instruction != 32'd63) saw_non_nop = 1'b1;
      if (o_done) begin
        got        = 1'b1;
        obs_result = o_result;
        obs_jaddr  = o_jump_address;
        obs_wb     = o_wb_en;
        obs_jdv    = o_jump_DV;
        obs_err    = o_error;
        done_instr = o_alu_instruction;
        break;
      end
      prev_instr = o_alu_instruction;
      @(posedge clk); #1;
      noise_jdv = 1'b0;
      cyc++;
    end
    noise_jdv = 1'b0;
    lat = got ? cyc : 0;
    if (got) begin
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, o_done}, 32'd0);
      check("ready_after_done", {31'd0, o_req_ready}, 32'd1);
    end
  endtask

  initial begin
    int done_seen;
    i_rst = 1'b1; i_flush = 1'b0; i_req_valid = 1'b1; noise_jdv = 1'b0; hang = 1'b0;
    i_op = OP_ADD; i_A = 32'd5; i_B = 32'd7; i_PC = 32'h40; i_IR = 32'h33;
    saw_non_nop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, o_req_ready}, 32'd0);
    check("rst_alu_instr", o_alu_instruction, 32'd63);
    check("rst_alu_state", {31'd0, o_alu_state}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_alu_A", o_alu_A, 32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    i_req_valid = 1'b0;
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("idle_alu_instr", o_alu_instruction, 32'd63);
    check("idle_ready", {31'd0, o_req_ready}, 32'd1);

    // ADD 5+7, with jump_DV noise on the ALU side outside the capture cycle
    run_op(OP_ADD, 32'd5, 32'd7, 32'h0, 32'h0, 1'b1);
    check("add_latency", lat, 32'd3);
    check("add_result", obs_result, 32'd12);
    check("add_wb", {31'd0, obs_wb}, 32'd1);
    check("add_jdv", {31'd0, obs_jdv}, 32'd0);
    check("add_err", {31'd0, obs_err}, 32'd0);

    // DIV -20/3
    run_op(OP_DIV, 32'hFFFFFFEC, 32'd3, 32'h0, 32'h0, 1'b0);
    check("div_latency", lat, 32'd6);
    check("div_result", obs_result, 32'hFFFFFFFA);
    check("div_wb", {31'd0, obs_wb}, 32'd1);
    check("div_op_held", prev_instr, 32'd14);
    check("div_nop_after", done_instr, 32'd63);

    // BEQ taken / not taken
    run_op(OP_BEQ, 32'd9, 32'd9, 32'h100, 32'd8, 1'b0);
    check("beq_latency", lat, 32'd3);
    check("beq_jdv", {31'd0, obs_jdv}, 32'd1);
    check("beq_jaddr", obs_jaddr, 32'h108);
    check("beq_wb", {31'd0, obs_wb}, 32'd0);
    run_op(OP_BEQ, 32'd9, 32'd8, 32'h100, 32'd8, 1'b0);
    check("bne_jdv", {31'd0, obs_jdv}, 32'd0);

    // Load: single-cycle, never writes back
    run_op(OP_LW, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0);
    check("lw_latency", lat, 32'd3);
    check("lw_wb", {31'd0, obs_wb}, 32'd0);
    check("lw_result", obs_result, 32'hDEADBEEF);

    // Invalid op
    run_op(6'd50, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0);
    check("inv_latency", lat, 32'd1);
    check("inv_err", {31'd0, obs_err}, 32'd1);
    check("inv_result", obs_result, 32'd0);
    check("inv_no_issue", {31'd0, saw_non_nop}, 32'd0);

    // Flush in IDLE blocks acceptance only
    i_flush = 1'b1; i_req_valid = 1'b1; i_op = OP_ADD;
    #1;
    check("idle_flush_ready", {31'd0, o_req_ready}, 32'd0);
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_flush = 1'b0;
    #1;
    check("idle_flush_state", {31'd0, o_alu_state}, 32'd0);
    check("idle_flush_ready_after", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    check("idle_flush_no_done", {31'd0, o_done}, 32'd0);

    // DIVU flushed in WAIT cycle 10, then ADD 1+1
    hang = 1'b1;
    start_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (10) begin @(posedge clk); #1; end
    check("divu_wait_instr", o_alu_instruction, 32'd15);
    check("divu_wait_state", {31'd0, o_alu_state}, 32'd1);
    i_flush = 1'b1;
    #1;
    check("flush_no_done", {31'd0, o_done}, 32'd0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    #1;
    check("flush_alu_state", {31'd0, o_alu_state}, 32'd0);
    check("flush_alu_instr", o_alu_instruction, 32'd63);
    check("flush_done", {31'd0, o_done}, 32'd0);
    hang = 1'b0;
    run_op(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0);
    check("post_flush_add", obs_result, 32'd2);

    // DIVU timeout
    hang = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);
    check("tmo_latency", lat, 32'd66);
    check("tmo_err", {31'd0, obs_err}, 32'd1);
    check("tmo_result", obs_result, 32'd0);
    check("tmo_wb", {31'd0, obs_wb}, 32'd0);

    // Reset mid-operation
    start_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    i_rst = 1'b1;
    #1;
    check("midrst_alu_state", {31'd0, o_alu_state}, 32'd0);
    check("midrst_alu_instr", o_alu_instruction, 32'd63);
    check("midrst_alu_A", o_alu_A, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    i_rst = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_done) done_seen++;
    end
    check("midrst_no_done", done_seen, 32'd0);
    check("midrst_ready", {31'd0, o_req_ready}, 32'd1);
    hang = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
